// File: rtl/width_packer_if.sv
// rtl/width_packer_if.sv - narrow-beat in / wide-word out handshake bundle for width_packer
interface width_packer_if #(
   parameter int IN_W  = 8,
   parameter int RATIO = 4
);
   logic [IN_W-1:0]       data_in;
   logic                  valid_in;
   logic                  in_ready;
   logic                  flush;
   logic [IN_W*RATIO-1:0] data_out;
   logic [RATIO-1:0]      data_keep;
   logic                  valid_out;
   logic                  out_ready;
   logic                  drop_pulse;

   modport slave (
      input  data_in, valid_in, flush, out_ready,
      output in_ready, data_out, data_keep, valid_out, drop_pulse
   );

   modport master (
      output data_in, valid_in, flush, out_ready,
      input  in_ready, data_out, data_keep, valid_out, drop_pulse
   );
endinterface

// File: rtl/width_packer.sv
// rtl/width_packer.sv - packs RATIO narrow beats into one wide word with flush, keep mask and gap handling
module width_packer #(
   parameter int IN_W      = 8,
   parameter int RATIO     = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit GAP_DROP  = 1'b1
) (
   input logic           clk_4f,
   input logic           reset,
   width_packer_if.slave bus
);
   localparam int W  = IN_W * RATIO;
   localparam int CW = $clog2(RATIO);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [RATIO-1:0] keep_q, keep_d;
   logic [W-1:0]     dout_q, dout_d;
   logic [RATIO-1:0] dkeep_q, dkeep_d;
   logic             vout_q, vout_d;
   logic             drop_q, drop_d;

   logic             in_ready, beat, complete, do_flush, gap;
   logic [W-1:0]     acc_beat;
   logic [RATIO-1:0] keep_beat;

   // Accumulator as it would look with this cycle's beat written into lane cnt.
   always_comb begin
      acc_beat  = acc_q;
      keep_beat = keep_q;
      for (int i = 0; i < RATIO; i++) begin
         if (cnt_q == CW'(i)) begin
            acc_beat[(MSB_FIRST ? (RATIO - 1 - i) : i) * IN_W +: IN_W] = bus.data_in;
            keep_beat[i] = 1'b1;
         end
      end
   end

   assign in_ready = !reset && (!vout_q || bus.out_ready);
   assign beat     = bus.valid_in && in_ready;
   assign complete = beat && (cnt_q == CW'(RATIO - 1));
   assign do_flush = bus.flush && in_ready && ((cnt_q != '0) || beat);
   // A held flush protects the partial word even while the output slot is blocked.
   assign gap      = !bus.valid_in && (cnt_q != '0) && !bus.flush;

   always_comb begin
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      keep_d  = keep_q;
      dout_d  = dout_q;
      dkeep_d = dkeep_q;
      vout_d  = vout_q && !bus.out_ready;
      drop_d  = 1'b0;
      if (complete || do_flush) begin
         dout_d  = beat ? acc_beat : acc_q;
         dkeep_d = beat ? keep_beat : keep_q;
         vout_d  = 1'b1;
         cnt_d   = '0;
         acc_d   = '0;
         keep_d  = '0;
      end else if (beat) begin
         acc_d  = acc_beat;
         keep_d = keep_beat;
         cnt_d  = cnt_q + CW'(1);
      end else if (gap && GAP_DROP) begin
         cnt_d  = '0;
         acc_d  = '0;
         keep_d = '0;
         drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk_4f) begin
      if (reset) begin
         cnt_q   <= '0;
         acc_q   <= '0;
         keep_q  <= '0;
         dout_q  <= '0;
         dkeep_q <= '0;
         vout_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         keep_q  <= keep_d;
         dout_q  <= dout_d;
         dkeep_q <= dkeep_d;
         vout_q  <= vout_d;
         drop_q  <= drop_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.data_out   = dout_q;
   assign bus.data_keep  = dkeep_q;
   assign bus.valid_out  = vout_q;
   assign bus.drop_pulse = drop_q;
endmodule

// File: tb/tb_width_packer.sv
// tb/tb_width_packer.sv - directed table and sequence checks for width_packer in three configurations
module tb_width_packer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   width_packer_if #(.IN_W(8), .RATIO(4)) ifa ();
   width_packer_if #(.IN_W(8), .RATIO(4)) ifb ();
   width_packer_if #(.IN_W(4), .RATIO(3)) ifc ();

   width_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .GAP_DROP(1'b1))
      dut_a (.clk_4f(clk), .reset(rst), .bus(ifa));
   width_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1'b1), .GAP_DROP(1'b0))
      dut_b (.clk_4f(clk), .reset(rst), .bus(ifb));
   width_packer #(.IN_W(4), .RATIO(3), .MSB_FIRST(1'b0), .GAP_DROP(1'b1))
      dut_c (.clk_4f(clk), .reset(rst), .bus(ifc));

   typedef struct {
      logic        v;
      logic [7:0]  d;
      logic        fl;
      logic        ev;
      logic [31:0] ed;
      logic [3:0]  ek;
      logic        edrop;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(logic v, logic [7:0] d, logic fl, logic ev,
                               logic [31:0] ed, logic [3:0] ek, logic edrop);
      vec_t r;
      r.v = v; r.d = d; r.fl = fl; r.ev = ev; r.ed = ed; r.ek = ek; r.edrop = edrop;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ifa.valid_in = 0; ifa.data_in = '0; ifa.flush = 0; ifa.out_ready = 1;
      ifb.valid_in = 0; ifb.data_in = '0; ifb.flush = 0; ifb.out_ready = 1;
      ifc.valid_in = 0; ifc.data_in = '0; ifc.flush = 0; ifc.out_ready = 1;

      // 8-to-32 stream: full words, back-to-back, flush, gap drop, flush corners
      vecs.push_back(mk(1, 8'hAA, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'hBB, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'hCC, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'hDD, 0, 1, 32'hAABBCCDD, 4'hF, 0));
      vecs.push_back(mk(1, 8'h01, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h02, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h03, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h04, 0, 1, 32'h01020304, 4'hF, 0));
      vecs.push_back(mk(1, 8'h05, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h06, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h07, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h08, 0, 1, 32'h05060708, 4'hF, 0));
      vecs.push_back(mk(1, 8'h11, 1, 1, 32'h11000000, 4'h1, 0));
      vecs.push_back(mk(1, 8'h11, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h22, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 1, 32'h11220000, 4'h3, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h11, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h22, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 32'h0,        4'h0, 1));
      vecs.push_back(mk(1, 8'h33, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h44, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h55, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h66, 0, 1, 32'h33445566, 4'hF, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h77, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h88, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'h99, 0, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(1, 8'hAA, 1, 1, 32'h778899AA, 4'hF, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 32'h0,        4'h0, 0));
      vecs.push_back(mk(0, 8'h00, 0, 0, 32'h0,        4'h0, 0));

      rst = 1;
      step();
      step();
      chk("rst_valid_out", 32'(ifa.valid_out), 32'h0);
      chk("rst_data_out", ifa.data_out, 32'h0);
      chk("rst_data_keep", 32'(ifa.data_keep), 32'h0);
      chk("rst_drop", 32'(ifa.drop_pulse), 32'h0);
      chk("rst_in_ready", 32'(ifa.in_ready), 32'h0);
      chk("rst_in_ready_c", 32'(ifc.in_ready), 32'h0);
      rst = 0;
      #1;
      chk("post_rst_in_ready", 32'(ifa.in_ready), 32'h1);
      step();

      for (int i = 0; i < vecs.size(); i++) begin
         ifa.valid_in = vecs[i].v;
         ifa.data_in  = vecs[i].d;
         ifa.flush    = vecs[i].fl;
         #1;
         chk($sformatf("vec%0d_in_ready", i), 32'(ifa.in_ready), 32'h1);
         step();
         chk($sformatf("vec%0d_valid_out", i), 32'(ifa.valid_out), 32'(vecs[i].ev));
         chk($sformatf("vec%0d_drop", i), 32'(ifa.drop_pulse), 32'(vecs[i].edrop));
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_data_out", i), ifa.data_out, vecs[i].ed);
            chk($sformatf("vec%0d_data_keep", i), 32'(ifa.data_keep), 32'(vecs[i].ek));
         end
      end
      ifa.valid_in = 0; ifa.flush = 0;

      // backpressure: pending word stalls the next beats until the consumer drains it
      ifa.out_ready = 0;
      begin
         logic [7:0] bp [4];
         bp[0] = 8'hAA; bp[1] = 8'hBB; bp[2] = 8'hCC; bp[3] = 8'hDD;
         for (int i = 0; i < 4; i++) begin
            ifa.valid_in = 1; ifa.data_in = bp[i];
            step();
         end
      end
      chk("bp_valid_out", 32'(ifa.valid_out), 32'h1);
      ifa.valid_in = 1; ifa.data_in = 8'hEE;
      #1;
      chk("bp_in_ready_low", 32'(ifa.in_ready), 32'h0);
      step();
      step();
      chk("bp_held_valid", 32'(ifa.valid_out), 32'h1);
      chk("bp_held_data", ifa.data_out, 32'hAABBCCDD);
      ifa.out_ready = 1;
      #1;
      chk("bp_in_ready_high", 32'(ifa.in_ready), 32'h1);
      step();
      chk("bp_drained", 32'(ifa.valid_out), 32'h0);
      begin
         logic [7:0] rs [3];
         rs[0] = 8'hFF; rs[1] = 8'h10; rs[2] = 8'h12;
         for (int i = 0; i < 3; i++) begin
            ifa.data_in = rs[i];
            step();
         end
      end
      chk("bp_resume_valid", 32'(ifa.valid_out), 32'h1);
      chk("bp_resume_data", ifa.data_out, 32'hEEFF1012);
      chk("bp_resume_keep", 32'(ifa.data_keep), 32'hF);
      ifa.valid_in = 0;
      step();

      // gap with hold: partial word survives an idle cycle
      ifb.valid_in = 1; ifb.data_in = 8'h11; step();
      ifb.data_in = 8'h22; step();
      ifb.valid_in = 0; step();
      chk("hold_gap_drop", 32'(ifb.drop_pulse), 32'h0);
      chk("hold_gap_valid", 32'(ifb.valid_out), 32'h0);
      ifb.valid_in = 1; ifb.data_in = 8'h33; step();
      ifb.data_in = 8'h44; step();
      chk("hold_valid", 32'(ifb.valid_out), 32'h1);
      chk("hold_data", ifb.data_out, 32'h11223344);
      ifb.valid_in = 0; step();

      // LSB-first 4x3 packing, then reset in the middle of a word
      for (int i = 1; i <= 3; i++) begin
         ifc.valid_in = 1; ifc.data_in = 4'(i);
         step();
      end
      chk("c_valid", 32'(ifc.valid_out), 32'h1);
      chk("c_data", 32'(ifc.data_out), 32'h321);
      chk("c_keep", 32'(ifc.data_keep), 32'h7);
      ifc.data_in = 4'h4; step();
      ifc.data_in = 4'h5; step();
      chk("c_partial_valid", 32'(ifc.valid_out), 32'h0);
      ifc.valid_in = 0;
      rst = 1;
      step();
      chk("c_rst_valid", 32'(ifc.valid_out), 32'h0);
      chk("c_rst_drop", 32'(ifc.drop_pulse), 32'h0);
      rst = 0;
      step();
      chk("c_after_rst_drop", 32'(ifc.drop_pulse), 32'h0);
      chk("c_after_rst_valid", 32'(ifc.valid_out), 32'h0);
      for (int i = 6; i <= 8; i++) begin
         ifc.valid_in = 1; ifc.data_in = 4'(i);
         step();
      end
      chk("c_clean_valid", 32'(ifc.valid_out), 32'h1);
      chk("c_clean_data", 32'(ifc.data_out), 32'h876);
      chk("c_clean_keep", 32'(ifc.data_keep), 32'h7);
      ifc.valid_in = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/width_packer.md
# width_packer

Parametrised serial-to-parallel word packer. Accepts RATIO narrow beats of IN_W bits and emits one IN_W*RATIO-bit word. Adds to the fixed 8-to-32 muxer:
- generic width and ratio;
- an output valid/ready handshake with backpressure;
- flush of partial words, with a lane-keep mask;
- selectable handling of gaps in valid_in.

It sits on the narrow-lane side of the datapath, ahead of the wide-word consumer, and runs entirely in the narrow-beat clock domain.

## Interface
- IN_W, 8: width of one input beat.
- RATIO, 4: beats per output word; at least 2.
- MSB_FIRST, 1:
  - 1: the first beat lands in the top lane, data_out[IN_W*RATIO-1 -: IN_W].
  - 0: the first beat lands in data_out[IN_W-1:0].
- GAP_DROP, 1:
  - 1: valid_in low mid-word discards the partial word.
  - 0: the partial word is held until beats resume.

Ports:
- clk_4f  in  1  single clock, rising edge only; beat-rate clock.
- reset  in  1  synchronous, active-high; clears all state.
- data_in  in  IN_W  input beat.
- valid_in  in  1  beat present.
- in_ready  out  1  beat accepted on a cycle where valid_in && in_ready.
- flush  in  1  emit the current partial word, padded with zeros.
- data_out  out  IN_W*RATIO  packed word.
- data_keep  out  RATIO  bit i set means lane i (i-th received beat) holds data.
- valid_out  out  1  word available.
- out_ready  in  1  consumer takes the word on valid_out && out_ready.
- drop_pulse  out  1  one-cycle pulse when a partial word is discarded because of a gap.

## Operation
State:
- beat counter cnt, 0..RATIO-1;
- accumulator acc;
- keep accumulator;
- one-entry output register (data_out/data_keep/valid_out).

Beat acceptance:
- in_ready = !reset && (!valid_out || out_ready). Combinational; the output slot is free or draining this cycle.
- Accepted beat with cnt < RATIO-1: write the beat into lane cnt of acc, set keep bit cnt, then cnt+1.
- Accepted beat with cnt == RATIO-1 (completing beat):
  - load acc plus that beat into data_out;
  - data_keep = all ones; valid_out = 1;
  - cnt = 0; acc and keep cleared.

Flush:
- flush && in_ready && (cnt > 0 or an accepted beat this cycle):
  - load the partial word into data_out, including any beat accepted this cycle;
  - unfilled lanes are 0; data_keep = filled lanes; valid_out = 1; cnt = 0.
- flush with cnt == 0 and no accepted beat: no effect.
- flush while in_ready = 0: ignored; the requester must hold it.

Gap (valid_in = 0, cnt > 0, no flush):
- GAP_DROP = 1: cnt = 0, acc and keep cleared, drop_pulse = 1 for one cycle.
- GAP_DROP = 0: nothing changes.

Other rules:
- A cycle with valid_in && !in_ready is neither a beat nor a gap: no state change, no drop.
- Output register: when valid_out && out_ready with no new load, valid_out clears. data_out and data_keep keep their last value; they are don't-care while valid_out = 0.

## Timing
Reset values (cycle after reset is sampled high):
- data_out = 0, data_keep = 0, valid_out = 0, drop_pulse = 0;
- cnt = 0, acc = 0;
- in_ready = 0 while reset is high, 1 on the first cycle after reset.

Latency and throughput:
- valid_out rises on the edge that accepts the completing beat or the flush, so data is visible the cycle after.
- Back-to-back words at full rate: one word every RATIO cycles with out_ready held high.
- Load and drain of the output register in the same cycle is legal: the new word replaces the old one, and valid_out stays 1.

Simultaneous events:
- flush with a completing beat: a full word is emitted, data_keep all ones, and the flush is consumed.
- flush with a gap under GAP_DROP = 1: flush wins, the partial word is emitted, no drop_pulse.
- Reset mid-word: partial data is discarded, drop_pulse is not raised, and any pending valid_out is lost.

Width rules:
- cnt is clog2(RATIO) bits.
- Lane i occupies bits [(RATIO-1-i)*IN_W +: IN_W] when MSB_FIRST = 1, and [i*IN_W +: IN_W] when MSB_FIRST = 0.

## Test plan
- Defaults, out_ready = 1, beats 0xAA, 0xBB, 0xCC, 0xDD on consecutive cycles -> one cycle later data_out = 0xAABBCCDD, data_keep = 4'b1111, valid_out high for 1 cycle.
- Eight consecutive beats 0x01..0x08 -> 0x01020304, then 0x05060708 four cycles later; no idle cycles, in_ready stays 1.
- Beats 0x11, 0x22, then flush with no beat -> data_out = 0x11220000, data_keep = 4'b0011.
- GAP_DROP = 1: beats 0x11, 0x22, one idle cycle, then 0x33, 0x44, 0x55, 0x66 -> drop_pulse for 1 cycle, then word 0x33445566. GAP_DROP = 0, same stimulus -> word 0x11223344.
- out_ready = 0 while word 0xAABBCCDD is pending -> in_ready = 0, valid_in beats stall with no data lost. Raising out_ready -> word drains, and stalled beats resume in order.
- MSB_FIRST = 0, IN_W = 4, RATIO = 3, nibbles 0x1, 0x2, 0x3 -> data_out = 12'h321. Reset after the second beat of the next word -> no output and no drop_pulse; the next three beats form a clean word.
